// File: rtl/nanov_digit_alu_if.sv
// Handshake and operand/result bundle for the digit-serial ALU.
// master drives start/op/operands; slave returns status, digits and flags.
interface nanov_digit_alu_if #(
   parameter int XLEN    = 32,
   parameter int DIGIT_W = 1
);
   logic               start;
   logic [3:0]         op;
   logic [XLEN-1:0]    a;
   logic [XLEN-1:0]    b;
   logic               busy;
   logic               done;
   logic               res_valid;
   logic [DIGIT_W-1:0] res_digit;
   logic [XLEN-1:0]    result;
   logic               eq;
   logic               lt;
   logic               ltu;

   modport master (
      output start, op, a, b,
      input  busy, done, res_valid, res_digit, result, eq, lt, ltu
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, res_valid, res_digit, result, eq, lt, ltu
   );
endinterface

// File: rtl/nanov_digit_alu.sv
// Digit-serial RV32I ALU: DIGIT_W bits per clock, LSB-first,
// with parallel result and A-B compare flags at done.
module nanov_digit_alu #(
   parameter int XLEN    = 32,
   parameter int DIGIT_W = 1
) (
   input logic              clk,
   input logic              rst,
   nanov_digit_alu_if.slave bus
);
   localparam int N  = XLEN / DIGIT_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(XLEN);
   localparam int DS = $clog2(DIGIT_W);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]    a_q, a_d;
   logic [XLEN-1:0]    b_q, b_d;
   logic [3:0]         op_q, op_d;
   logic               add_c_q, add_c_d;
   logic               cmp_c_q, cmp_c_d;
   logic               ne_q, ne_d;
   logic               dmsb_q, dmsb_d;
   logic [XLEN-1:0]    acc_q, acc_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               vld_q, vld_d;
   logic [DIGIT_W-1:0] dig_q, dig_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic               eq_q, eq_d;
   logic               lt_q, lt_d;
   logic               ltu_q, ltu_d;

   logic               accept;
   logic [XLEN-1:0]    sa, sb;
   logic [3:0]         so, opn;
   logic [CW-1:0]      idx;
   logic [SW-1:0]      off, shamt;
   logic [DIGIT_W-1:0] a_dig, b_dig, sh_dig, dig;
   logic [DIGIT_W:0]   add_sum, cmp_sum;
   logic               sub, is_cmp, cin_add, cin_cmp;
   logic [SW:0]        pos, pl, pr;
   logic               eq_f, lt_f, ltu_f;

   // Digit 0 is computed straight from the inputs on the accepting edge.
   always_comb begin : datapath
      accept  = bus.start && (state_q != RUN);
      sa      = accept ? bus.a : a_q;
      sb      = accept ? bus.b : b_q;
      so      = accept ? bus.op : op_q;
      opn     = so;
      if (so[3] && so != OP_SUB && so != OP_SRA)
         opn = {1'b0, so[2:0]};
      sub     = (opn == OP_SUB);
      is_cmp  = (opn == OP_SLT) || (opn == OP_SLTU);
      idx     = accept ? '0 : cnt_q + 1'b1;
      off     = SW'(idx) << DS;
      a_dig   = DIGIT_W'(sa >> off);
      b_dig   = DIGIT_W'(sb >> off);
      cin_add = accept ? sub : add_c_q;
      cin_cmp = accept ? 1'b1 : cmp_c_q;
      add_sum = {1'b0, a_dig} + {1'b0, sub ? ~b_dig : b_dig}
              + (DIGIT_W+1)'(cin_add);
      cmp_sum = {1'b0, a_dig} + {1'b0, ~b_dig}
              + (DIGIT_W+1)'(cin_cmp);
      shamt   = sb[SW-1:0];
      sh_dig  = '0;
      pos     = '0;
      pl      = '0;
      pr      = '0;
      for (int j = 0; j < DIGIT_W; j++) begin
         pos = {1'b0, off} + (SW+1)'(j);
         pl  = pos - {1'b0, shamt};
         pr  = pos + {1'b0, shamt};
         if (opn == OP_SLL)
            sh_dig[j] = pl[SW] ? 1'b0 : sa[pl[SW-1:0]];
         else if (pr[SW])
            sh_dig[j] = (opn == OP_SRA) & sa[XLEN-1];
         else
            sh_dig[j] = sa[pr[SW-1:0]];
      end
      unique case (opn)
         OP_ADD, OP_SUB:         dig = add_sum[DIGIT_W-1:0];
         OP_SLL, OP_SRL, OP_SRA: dig = sh_dig;
         OP_XOR:                 dig = a_dig ^ b_dig;
         OP_OR:                  dig = a_dig | b_dig;
         OP_AND:                 dig = a_dig & b_dig;
         default:                dig = '0;
      endcase
      eq_f  = ~ne_q;
      ltu_f = ~cmp_c_q;
      lt_f  = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : dmsb_q;
   end

   always_comb begin : control
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      add_c_d  = add_c_q;
      cmp_c_d  = cmp_c_q;
      ne_d     = ne_q;
      dmsb_d   = dmsb_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      vld_d    = vld_q;
      dig_d    = dig_q;
      result_d = result_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      ltu_d    = ltu_q;
      if (accept || (state_q == RUN && cnt_q != CW'(N-1))) begin
         add_c_d = add_sum[DIGIT_W];
         cmp_c_d = cmp_sum[DIGIT_W];
         dmsb_d  = cmp_sum[DIGIT_W-1];
         dig_d   = dig;
         acc_d   = (acc_q >> DIGIT_W)
                 | (XLEN'(dig) << (XLEN - DIGIT_W));
      end
      if (accept) begin
         state_d = RUN;
         cnt_d   = '0;
         a_d     = bus.a;
         b_d     = bus.b;
         op_d    = bus.op;
         ne_d    = (a_dig != b_dig);
         busy_d  = 1'b1;
         vld_d   = ~is_cmp;
      end else if (state_q == RUN) begin
         if (cnt_q == CW'(N-1)) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            vld_d    = 1'b0;
            done_d   = 1'b1;
            eq_d     = eq_f;
            lt_d     = lt_f;
            ltu_d    = ltu_f;
            result_d = acc_q;
            if (opn == OP_SLT)  result_d = XLEN'(lt_f);
            if (opn == OP_SLTU) result_d = XLEN'(ltu_f);
         end else begin
            cnt_d = cnt_q + 1'b1;
            ne_d  = ne_q | (a_dig != b_dig);
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         add_c_q  <= 1'b0;
         cmp_c_q  <= 1'b0;
         ne_q     <= 1'b0;
         dmsb_q   <= 1'b0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         vld_q    <= 1'b0;
         dig_q    <= '0;
         result_q <= '0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         ltu_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         add_c_q  <= add_c_d;
         cmp_c_q  <= cmp_c_d;
         ne_q     <= ne_d;
         dmsb_q   <= dmsb_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         vld_q    <= vld_d;
         dig_q    <= dig_d;
         result_q <= result_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         ltu_q    <= ltu_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res_valid = vld_q;
   assign bus.res_digit = dig_q;
   assign bus.result    = result_q;
   assign bus.eq        = eq_q;
   assign bus.lt        = lt_q;
   assign bus.ltu       = ltu_q;
endmodule

// File: tb/tb_nanov_digit_alu.sv
// Directed bench for nanov_digit_alu at DIGIT_W = 1, 4 and 32.
// Expected values are hand-computed constants.
module tb_nanov_digit_alu;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   nanov_digit_alu_if #(.XLEN(32), .DIGIT_W(1))  if1 ();
   nanov_digit_alu_if #(.XLEN(32), .DIGIT_W(4))  if4 ();
   nanov_digit_alu_if #(.XLEN(32), .DIGIT_W(32)) if32 ();

   nanov_digit_alu #(.XLEN(32), .DIGIT_W(1)) u1 (
      .clk(clk), .rst(rst), .bus(if1)
   );
   nanov_digit_alu #(.XLEN(32), .DIGIT_W(4)) u4 (
      .clk(clk), .rst(rst), .bus(if4)
   );
   nanov_digit_alu #(.XLEN(32), .DIGIT_W(32)) u32 (
      .clk(clk), .rst(rst), .bus(if32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] flg(input logic e, input logic l,
                                       input logic u);
      return {29'b0, e, l, u};
   endfunction

   // Start on a negedge, scramble inputs after accept, collect digits.
   task automatic run1(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] dw,
                       output int nv, output int nd);
      @(negedge clk);
      if1.start = 1'b1; if1.op = op; if1.a = a; if1.b = b;
      @(negedge clk);
      if1.start = 1'b0; if1.op = 4'b0110; if1.a = ~a; if1.b = ~b;
      dw = '0; nv = 0; nd = 0;
      for (int k = 0; k < 32; k++) begin
         if (if1.res_valid) begin dw[k] = if1.res_digit[0]; nv++; end
         if (if1.done) nd++;
         @(negedge clk);
      end
   endtask

   task automatic run4(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] dw,
                       output int nv, output int nd);
      @(negedge clk);
      if4.start = 1'b1; if4.op = op; if4.a = a; if4.b = b;
      @(negedge clk);
      if4.start = 1'b0; if4.op = 4'b0110; if4.a = ~a; if4.b = ~b;
      dw = '0; nv = 0; nd = 0;
      for (int k = 0; k < 8; k++) begin
         if (if4.res_valid) begin dw[k*4 +: 4] = if4.res_digit; nv++; end
         if (if4.done) nd++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] dw;
      int nv;
      int nd;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      if1.start = 0; if1.op = 0; if1.a = 0; if1.b = 0;
      if4.start = 0; if4.op = 0; if4.a = 0; if4.b = 0;
      if32.start = 0; if32.op = 0; if32.a = 0; if32.b = 0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {29'b0, if1.busy, if1.done, if1.res_valid}, 0);
      chk("rst_res", if1.result | if4.result | if32.result, 0);
      chk("rst_flg", flg(if4.eq, if4.lt, if4.ltu), 0);
      chk("rst_dig", 32'(if4.res_digit), 0);
      rst = 1'b0;

      // Defaults: carry ripples through all 32 single-bit digits.
      run1(4'b0000, 32'hFFFF_FFFF, 32'h1, dw, nv, nd);
      chk("add1_nv", nv, 32);
      chk("add1_dw", dw, 32'h0);
      chk("add1_early", nd, 0);
      chk("add1_done", {30'b0, if1.done, if1.busy}, 32'h2);
      chk("add1_res", if1.result, 32'h0);
      chk("add1_flg", flg(if1.eq, if1.lt, if1.ltu), flg(0, 1, 0));
      @(negedge clk);
      chk("add1_pulse", 32'(if1.done), 0);

      run4(4'b1000, 32'h5, 32'h7, dw, nv, nd);
      chk("sub_dw", dw, 32'hFFFF_FFFE);
      chk("sub_res", if4.result, 32'hFFFF_FFFE);
      chk("sub_done", 32'(if4.done), 1);
      chk("sub_flg", flg(if4.eq, if4.lt, if4.ltu), flg(0, 1, 1));

      run4(4'b1101, 32'h8000_0000, 32'h24, dw, nv, nd);
      chk("sra_dw", dw, 32'hF800_0000);
      chk("sra_res", if4.result, 32'hF800_0000);
      chk("sra_last", 32'(dw[31:28]), 32'hF);

      run4(4'b0101, 32'h8000_0000, 32'h24, dw, nv, nd);
      chk("srl_res", if4.result, 32'h0800_0000);
      chk("srl_dw", dw, 32'h0800_0000);

      run4(4'b0011, 32'h8000_0000, 32'h1, dw, nv, nd);
      chk("sltu_nv", nv, 0);
      chk("sltu_res", if4.result, 32'h0);
      chk("sltu_flg", flg(if4.eq, if4.lt, if4.ltu), flg(0, 1, 0));

      run4(4'b0010, 32'h8000_0000, 32'h1, dw, nv, nd);
      chk("slt_nv", nv, 0);
      chk("slt_res", if4.result, 32'h1);

      run4(4'b1100, 32'hF0F0_1234, 32'h0FF0_00FF, dw, nv, nd);
      chk("xor_alias", if4.result, 32'hFF00_12CB);

      run4(4'b1001, 32'h1, 32'hFFFF_FFE3, dw, nv, nd);
      chk("sll_alias", if4.result, 32'h8);
      chk("sll_flg", flg(if4.eq, if4.lt, if4.ltu), flg(0, 0, 1));

      run4(4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, dw, nv, nd);
      chk("and_res", if4.result, 32'h0F00_0F00);
      run4(4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, dw, nv, nd);
      chk("or_res", if4.result, 32'hFF0F_FF0F);

      run4(4'b0000, 32'h1234, 32'h1234, dw, nv, nd);
      chk("eq_res", if4.result, 32'h2468);
      chk("eq_flg", flg(if4.eq, if4.lt, if4.ltu), flg(1, 0, 0));

      // A start pulse in mid-run must be dropped, not queued.
      @(negedge clk);
      if4.start = 1; if4.op = 4'b0000; if4.a = 32'h100; if4.b = 32'h23;
      @(negedge clk);
      if4.start = 0;
      repeat (3) @(negedge clk);
      if4.start = 1; if4.op = 4'b1000; if4.a = 32'hFFFF; if4.b = 32'h1;
      @(negedge clk);
      if4.start = 0;
      chk("mid_busy", 32'(if4.busy), 1);
      repeat (4) @(negedge clk);
      chk("mid_done", 32'(if4.done), 1);
      chk("mid_res", if4.result, 32'h123);
      @(negedge clk);
      chk("mid_noq", {30'b0, if4.busy, if4.done}, 0);

      // Start held through DONE gives back-to-back operations.
      @(negedge clk);
      if4.start = 1; if4.op = 4'b0000; if4.a = 32'h1; if4.b = 32'h2;
      repeat (8) @(negedge clk);
      chk("b2b_e7", {30'b0, if4.busy, if4.done}, 32'h2);
      @(negedge clk);
      chk("b2b_d1", 32'(if4.done), 1);
      chk("b2b_r1", if4.result, 32'h3);
      if4.a = 32'd10; if4.b = 32'd20;
      @(negedge clk);
      if4.start = 0;
      chk("b2b_busy", {30'b0, if4.busy, if4.res_valid}, 32'h3);
      chk("b2b_dig0", 32'(if4.res_digit), 32'hE);
      chk("b2b_nodone", 32'(if4.done), 0);
      repeat (8) @(negedge clk);
      chk("b2b_d2", 32'(if4.done), 1);
      chk("b2b_r2", if4.result, 32'h1E);

      // Single-digit configuration: done follows edge 1.
      @(negedge clk);
      if32.start = 1; if32.op = 4'b0000;
      if32.a = 32'h7FFF_FFFF; if32.b = 32'h1;
      @(negedge clk);
      if32.start = 0;
      chk("n1_run", {29'b0, if32.busy, if32.res_valid, if32.done}, 32'h6);
      chk("n1_dig", if32.res_digit, 32'h8000_0000);
      @(negedge clk);
      chk("n1_done", {30'b0, if32.busy, if32.done}, 32'h1);
      chk("n1_res", if32.result, 32'h8000_0000);
      chk("n1_flg", flg(if32.eq, if32.lt, if32.ltu), 0);

      // Reset in mid-run aborts and clears the held result.
      run1(4'b0000, 32'h1234_5678, 32'h1, dw, nv, nd);
      chk("pre_res", if1.result, 32'h1234_5679);
      @(negedge clk);
      if1.start = 1; if1.op = 0; if1.a = 32'hAAAA; if1.b = 32'h1;
      @(negedge clk);
      if1.start = 0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ctl", {30'b0, if1.busy, if1.res_valid}, 0);
      chk("abort_res", if1.result, 0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (if1.done || if1.busy) nd++;
         @(negedge clk);
      end
      chk("abort_idle", nd, 0);
      run1(4'b0000, 32'h7, 32'h8, dw, nv, nd);
      chk("post_done", 32'(if1.done), 1);
      chk("post_res", if1.result, 32'hF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
